// File: rtl/freq_meter_if.sv
// Measurement port bundle: stimulus and control toward the meter, result back.
// Handshake: valid is a one-cycle strobe with no ready; count/overflow are stable until the next valid.
interface freq_meter_if #(
    parameter int CNT_W = 8
);
    logic             sig_in;
    logic             start;
    logic             cont;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             valid;
    logic             overflow;
    logic             fsm_state;

    modport master (
        output sig_in, start, cont,
        input  busy, count, valid, overflow, fsm_state
    );

    modport slave (
        input  sig_in, start, cont,
        output busy, count, valid, overflow, fsm_state
    );
endinterface

// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronised rising edges of sig_in over GATE_CYCLES clk cycles.
// Result is registered and announced with a one-cycle valid strobe; fsm_state mirrors the FSM.
module freq_meter #(
    parameter int GATE_CYCLES = 100,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    freq_meter_if.slave   bus
);
    localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;

    typedef enum logic {IDLE = 1'b0, GATE = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [GW-1:0]          gate_q;
    logic [CNT_W-1:0]       edge_q, edge_nx;
    logic                   ovf_q, ovf_nx;
    logic [CNT_W-1:0]       count_q;
    logic                   overflow_q;
    logic                   valid_q;
    logic                   rise;
    logic                   sat;
    logic                   last;
    logic                   open;

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign sat  = (edge_q == {CNT_W{1'b1}});

    always_comb begin
        state_d = state_q;
        open    = 1'b0;
        last    = 1'b0;
        edge_nx = edge_q;
        ovf_nx  = ovf_q;
        if (rise && !sat) edge_nx = edge_q + CNT_W'(1);
        if (rise && sat)  ovf_nx  = 1'b1;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = GATE;
                    open    = 1'b1;
                end
            end
            GATE: begin
                last = (gate_q == '0);
                if (last && !bus.cont) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= '0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
            prev_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    // The last gate cycle both latches the result (including its own edge) and
    // reloads the counters, so back-to-back windows lose nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q     <= '0;
            edge_q     <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (open || last) begin
                gate_q <= GW'(GATE_CYCLES - 1);
                edge_q <= '0;
                ovf_q  <= 1'b0;
            end else if (state_q == GATE) begin
                gate_q <= gate_q - GW'(1);
                edge_q <= edge_nx;
                ovf_q  <= ovf_nx;
            end
            if (last) begin
                count_q    <= edge_nx;
                overflow_q <= ovf_nx;
                valid_q    <= 1'b1;
            end
        end
    end

    assign bus.busy      = (state_q == GATE);
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.valid     = valid_q;
    assign bus.fsm_state = state_q;
endmodule
